// File: rtl/arb4_sel.sv
// arb4_sel: four-requester round-robin arbiter with registered one-hot grant
// and binary select for a downstream 4:1 result mux.
// Optional feature: define ARB4_TIMEOUT_EN to enable a grant-hold limit of
// TIMEOUT cycles, an 8-bit hold counter and the timeout_err pulse output.
module arb4_sel #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
`ifdef ARB4_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  // Out-of-range hold limits are rejected at elaboration.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
    $error("arb4_sel: TIMEOUT must lie in 2..255");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;
  logic [1:0] sel_r, sel_s;
  logic [3:0] gnt_r, gnt_s;
  logic       busy_r, busy_s;
  logic [1:0] pick_s;
  logic       abandon_s;

`ifdef ARB4_TIMEOUT_EN
  localparam logic [7:0] TOUT_LAST_C = 8'(TIMEOUT - 1);
  logic [7:0] cnt_r, cnt_s;
  logic       terr_r, terr_s;
`endif

  // First set request bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // Scanning from the farthest offset back lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s    = rr_pick(req, ptr_r);
  assign abandon_s = ~req[sel_r];

  // Next-state logic: grant selection in IDLE, release detection in GRANT.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = sel_r;
    gnt_s   = gnt_r;
    busy_s  = busy_r;
`ifdef ARB4_TIMEOUT_EN
    cnt_s   = cnt_r;
    terr_s  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        // done is deliberately not looked at here.
        if (req != 4'b0000) begin
          state_s = GRANT;
          sel_s   = pick_s;
          gnt_s   = 4'b0001 << pick_s;
          busy_s  = 1'b1;
`ifdef ARB4_TIMEOUT_EN
          cnt_s   = 8'd0;
`endif
        end else begin
          gnt_s  = 4'b0000;
          busy_s = 1'b0;
        end
      end
      GRANT: begin
        // done and abandon together form a single release.
        if (done || abandon_s) begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
          ptr_s   = sel_r + 2'd1;
        end
`ifdef ARB4_TIMEOUT_EN
        else if (cnt_r == TOUT_LAST_C) begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          busy_s  = 1'b0;
          ptr_s   = sel_r + 2'd1;
          terr_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
`else
        else begin
          gnt_s = gnt_r;
        end
`endif
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      sel_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      busy_r  <= 1'b0;
`ifdef ARB4_TIMEOUT_EN
      cnt_r   <= 8'd0;
      terr_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      sel_r   <= sel_s;
      gnt_r   <= gnt_s;
      busy_r  <= busy_s;
`ifdef ARB4_TIMEOUT_EN
      cnt_r   <= cnt_s;
      terr_r  <= terr_s;
`endif
    end
  end

  assign gnt  = gnt_r;
  assign sel  = sel_r;
  assign busy = busy_r;
`ifdef ARB4_TIMEOUT_EN
  assign timeout_err = terr_r;
`endif

endmodule

// File: tb/tb_arb4_sel.sv
// tb_arb4_sel: directed scenarios plus randomized traffic for arb4_sel,
// checked against a transaction-level round-robin model.
module tb_arb4_sel;

`ifdef ARB4_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TO_EN      = 1'b1;
`else
  localparam int TB_TIMEOUT = 16;
  localparam bit TO_EN      = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
`ifdef ARB4_TIMEOUT_EN
  logic       timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  // reference model: who owns the resource, where the search starts next
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;
  bit m_terr;
  int waits[4];
  bit pbusy;

  arb4_sel #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .sel         (sel),
    .busy        (busy)
`ifdef ARB4_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  // free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_terr = 1'b0;
    pbusy  = 1'b0;
    for (int i = 0; i < 4; i++) waits[i] = 0;
  endtask

  // one clock edge of the arbitration rules, from the inputs seen at the edge
  task automatic model_edge();
    bit rel;
    bit to;
    if (!m_busy) begin
      m_terr = 1'b0;
      if (req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      rel = done || !req[m_sel];
      to  = TO_EN && !rel && (m_cnt == TB_TIMEOUT - 1);
      if (rel || to) begin
        m_busy = 1'b0;
        m_ptr  = (m_sel + 1) % 4;
        m_terr = to;
      end else begin
        m_cnt++;
        m_terr = 1'b0;
      end
    end
  endtask

  task automatic compare(input logic [3:0] r_at);
    int g;
    chk("gnt", 32'(gnt), m_busy ? (32'd1 << m_sel) : 32'd0);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef ARB4_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
`endif
    // fairness: a steady requester sees at most 3 other grants before its own
    if (!pbusy && busy) begin
      g = int'(sel);
      for (int i = 0; i < 4; i++) begin
        if (i == g) begin
          chk("fair_wait", 32'(waits[i] <= 3), 32'd1);
          waits[i] = 0;
        end else if (r_at[i]) begin
          waits[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) if (!r_at[i]) waits[i] = 0;
    pbusy = busy;
  endtask

  task automatic step();
    logic [3:0] r_at;
    r_at = req;
    model_edge();
    @(posedge clk);
    #1;
    compare(r_at);
  endtask

  // asynchronous reset pulse, checked before any clock edge sees it
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ARB4_TIMEOUT_EN
    chk("rst_terr", 32'(timeout_err), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_gnt", 32'(gnt), 32'd0);
    chk("por_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // idle with no request; done in IDLE is ignored
    done = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);
    done = 1'b0;

    // single request to 2, release by done, pointer moves to 3
    req = 4'b0100;
    step();
    chk("r27_gnt", 32'(gnt), 32'b0100);
    chk("r27_sel", 32'(sel), 32'd2);
    done = 1'b1;
    step();
    chk("r27_rel_gnt", 32'(gnt), 32'd0);
    chk("r27_rel_sel", 32'(sel), 32'd2);
    done = 1'b0;
    req  = 4'b1111;
    step();
    chk("r27_ptr3", 32'(sel), 32'd3);
    done = 1'b1;
    step();
    done = 1'b0;

    // all requesting: order 0,1,2,3,0 with one idle cycle between grants
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("r28_sel", 32'(sel), 32'(i % 4));
      chk("r28_gnt", 32'(gnt), 32'd1 << (i % 4));
      done = 1'b1;
      step();
      chk("r28_gap", 32'(gnt), 32'd0);
      done = 1'b0;
    end

    // requester 1 abandons; next grant goes to 2
    do_reset();
    req = 4'b0010;
    step();
    chk("r29_sel1", 32'(sel), 32'd1);
    req = 4'b1101;
    step();
    chk("r29_rel", 32'(gnt), 32'd0);
    step();
    chk("r29_next", 32'(gnt), 32'b0100);

    // done and abandon together: one release, pointer advances once
    done = 1'b1;
    req  = 4'b1001;
    step();
    chk("r30_rel", 32'(gnt), 32'd0);
    done = 1'b0;
    step();
    chk("r30_next", 32'(gnt), 32'b1000);

    // reset mid-grant to 3, then 0 wins with req 1001
    do_reset();
    step();
    chk("r31_next", 32'(gnt), 32'b0001);
    done = 1'b1;
    step();
    done = 1'b0;

`ifdef ARB4_TIMEOUT_EN
    // forced release after TIMEOUT grant cycles
    do_reset();
    req = 4'b0001;
    step();
    chk("r32_gnt", 32'(gnt), 32'b0001);
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      step();
      chk("r32_hold", 32'(gnt), 32'b0001);
    end
    step();
    chk("r32_drop", 32'(gnt), 32'd0);
    chk("r32_terr", 32'(timeout_err), 32'd1);
    step();
    chk("r32_regrant", 32'(gnt), 32'b0001);
    chk("r32_terr_end", 32'(timeout_err), 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb4_sel.md
ARB4_SEL -- requirements
Module: arb4_sel

Parameters
- REQ-001: TIMEOUT, default 16: cycles a grant may be held before forced release; legal range 2..255; only used when ARB4_TIMEOUT_EN is defined.

Interface
- REQ-002: clk  input  1  single clock; all state updates on the rising edge.
- REQ-003: rst  input  1  reset, asynchronous and active-high.
- REQ-004: req  input  4  request per requester; bit i belongs to requester i; level-sensitive.
- REQ-005: done  input  1  served resource signals that the current transaction is complete.
- REQ-006: gnt  output  4  one-hot grant, or all-zero; registered.
- REQ-007: sel  output  2  binary index of the granted requester; drives the sel port of the 4:1 result mux; registered.
- REQ-008: busy  output  1  high while any grant is active.
- REQ-009: timeout_err  output  1  one-cycle pulse on forced release; present only with ARB4_TIMEOUT_EN.

Function
- REQ-010: The block SHALL implement a two-state FSM, IDLE and GRANT, plus a 2-bit round-robin pointer ptr.
- REQ-011: In IDLE with req != 0, the block SHALL grant the first set req bit, searching ptr, ptr+1, ptr+2, ptr+3 modulo 4, and SHALL enter GRANT on the next edge.
- REQ-012: In IDLE with req == 0, the block SHALL hold gnt = 0 and stay in IDLE.
- REQ-013: On entering GRANT, gnt, sel and busy SHALL be updated on the same edge; gnt SHALL equal 1 << sel.
- REQ-014: Grant latency SHALL be exactly 1 cycle from a req sampled in IDLE to gnt asserted.
- REQ-015: In GRANT, gnt and sel SHALL stay stable until release, independent of other req bits.
- REQ-016: A release SHALL occur when done = 1, or when req[sel] = 0 (requester abandons); both at once SHALL count as one release.
- REQ-017: On a release edge, the FSM SHALL return to IDLE, gnt and busy SHALL go to 0, ptr SHALL become sel + 1 modulo 4, and sel SHALL keep its last value.
- REQ-018: After a release, the next grant SHALL occur no earlier than the following cycle, giving a minimum 1-cycle idle gap between grants.
- REQ-019: done sampled while in IDLE SHALL be ignored.
- REQ-020: ptr wrap-around from 3 SHALL go to 0.
- REQ-021: No requester continuously asserting req SHALL wait more than 3 complete grants of other requesters.

Reset
- REQ-022: While rst is high, the block SHALL force state = IDLE, gnt = 0, sel = 0, busy = 0, ptr = 0, timeout_err = 0, and the timeout counter to 0, asynchronously.
- REQ-023: Reset asserted mid-grant SHALL drop gnt immediately without a release pulse; the first grant after reset deassertion SHALL occur no earlier than the first edge at which rst is low.

Configuration
- REQ-024: With macro ARB4_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
- REQ-025: If the counter reaches TIMEOUT-1 without a release, the next edge SHALL force a release per REQ-017 and pulse timeout_err for 1 cycle.
- REQ-026: Without ARB4_TIMEOUT_EN, the counter and the timeout_err port SHALL be absent, and grants SHALL be held indefinitely.

Verification
- REQ-027: Reset, then req = 4'b0100: gnt = 4'b0100 and sel = 2 one cycle later; done pulse gives gnt = 0 and ptr = 3.
- REQ-028: req = 4'b1111 held, done pulsed every grant: grant order 0, 1, 2, 3, 0, each separated by 1 idle cycle.
- REQ-029: Grant to requester 1 active, then req changes to 4'b1101 (requester 1 abandons): gnt = 0 next edge and ptr = 2; following grant goes to requester 2.
- REQ-030: Simultaneous done and req[sel] drop: exactly one release; ptr advances once.
- REQ-031: rst pulsed while gnt = 4'b1000: gnt = 0 within the reset pulse and ptr = 0; after release with req = 4'b1001, grant goes to requester 0.
- REQ-032: ARB4_TIMEOUT_EN with TIMEOUT = 4, req = 4'b0001, done held 0: timeout_err pulses, gnt drops after 4 GRANT cycles, and re-grant to requester 0 follows.
